// File: rtl/ddr4_cmd_scheduler.sv
// rtl/ddr4_cmd_scheduler.sv - DDR4 bank-aware command sequencer; macro DDR4_AUTO_REFRESH_EN adds an internal tREFI refresh source
module ddr4_cmd_scheduler #(
    parameter int BG_BITS  = 1,
    parameter int BA_BITS  = 2,
    parameter int ROW_BITS = 17,
    parameter int COL_BITS = 10,
    parameter int T_RP     = 4,
    parameter int T_RCD    = 4,
    parameter int T_RAS    = 10,
    parameter int T_RFC    = 20,
    parameter int T_REFI   = 200,
    parameter int CL       = 5,
    parameter int CWL      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [BG_BITS-1:0]  req_bg,
    input  logic [BA_BITS-1:0]  req_ba,
    input  logic [ROW_BITS-1:0] req_row,
    input  logic [COL_BITS-1:0] req_col,
    input  logic                refresh,
    output logic                cs_n,
    output logic                act_n,
    output logic                ras_n,
    output logic                cas_n,
    output logic                we_n,
    output logic [BG_BITS-1:0]  bg,
    output logic [BA_BITS-1:0]  ba,
    output logic [ROW_BITS-1:0] addr,
    output logic                rd_data_en,
    output logic                wr_data_en,
    output logic                busy
);

    localparam int IW   = BG_BITS + BA_BITS;
    localparam int NB   = 1 << IW;
    localparam int TMAX = (T_RFC > T_RP) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                         : ((T_RP > T_RCD) ? T_RP : T_RCD);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(T_RAS + 1);

    typedef enum logic [3:0] {
        IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RDWR, PREA, WAIT_RPA, REF, WAIT_RFC
    } state_t;

    state_t                state, next_state;
    logic [TW-1:0]         timer;
    logic [NB-1:0]         bank_open;
    logic [ROW_BITS-1:0]   bank_row [NB];
    logic [RW-1:0]         tras_cnt [NB];
    logic                  ref_pend;
    logic                  lat_write;
    logic [BG_BITS-1:0]    lat_bg;
    logic [BA_BITS-1:0]    lat_ba;
    logic [ROW_BITS-1:0]   lat_row;
    logic [COL_BITS-1:0]   lat_col;
    logic [CL-1:0]         rd_pipe;
    logic [CWL-1:0]        wr_pipe;
    logic [IW-1:0]         req_idx, lat_idx;
    logic                  all_tras_zero, any_open, accept, auto_tick;
    logic                  do_act, do_pre, do_prea, do_ref, do_rd, do_wr;

    assign req_idx    = {req_bg, req_ba};
    assign lat_idx    = {lat_bg, lat_ba};
    assign any_open   = |bank_open;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != IDLE);
    assign rd_data_en = rd_pipe[CL-1];
    assign wr_data_en = wr_pipe[CWL-1];

`ifdef DDR4_AUTO_REFRESH_EN
    localparam int FW = $clog2(T_REFI + 1);
    logic [FW-1:0] refi_cnt;

    // Free-running refresh interval counter; fires on zero and reloads.
    always_ff @(posedge clk) begin
        if (reset)              refi_cnt <= FW'(T_REFI);
        else if (refi_cnt == 0) refi_cnt <= FW'(T_REFI - 1);
        else                    refi_cnt <= refi_cnt - 1'b1;
    end
    assign auto_tick = (refi_cnt == 0);
`else
    // No internal refresh source; T_REFI only matters when auto refresh is compiled in.
    assign auto_tick = (T_REFI < 0);
`endif

    // PRE/PREA may only issue once every relevant tRAS window has closed.
    always_comb begin
        all_tras_zero = 1'b1;
        for (int i = 0; i < NB; i++)
            if (tras_cnt[i] != 0) all_tras_zero = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state, command issue and pin decode; reset forces DES and not-ready.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        do_act = 1'b0; do_pre = 1'b0; do_prea = 1'b0;
        do_ref = 1'b0; do_rd  = 1'b0; do_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    next_state = any_open ? PREA : REF;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (bank_open[req_idx] && bank_row[req_idx] == req_row) next_state = RDWR;
                        else if (bank_open[req_idx])                            next_state = PRE;
                        else                                                    next_state = ACT;
                    end
                end
            end
            PRE:      if (tras_cnt[lat_idx] == 0) begin do_pre = 1'b1; next_state = WAIT_RP; end
            WAIT_RP:  if (timer <= TW'(1)) next_state = ACT;
            ACT:      begin do_act = 1'b1; next_state = WAIT_RCD; end
            WAIT_RCD: if (timer <= TW'(1)) next_state = RDWR;
            RDWR:     begin do_rd = !lat_write; do_wr = lat_write; next_state = IDLE; end
            PREA:     if (all_tras_zero) begin do_prea = 1'b1; next_state = WAIT_RPA; end
            WAIT_RPA: if (timer <= TW'(1)) next_state = REF;
            REF:      begin do_ref = 1'b1; next_state = WAIT_RFC; end
            WAIT_RFC: if (timer <= TW'(1)) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (reset) begin
            req_ready = 1'b0;
            do_act = 1'b0; do_pre = 1'b0; do_prea = 1'b0;
            do_ref = 1'b0; do_rd  = 1'b0; do_wr   = 1'b0;
        end
        cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        bg   = '0;   ba    = '0;   addr  = '0;
        if (do_act) begin
            cs_n = 1'b0; act_n = 1'b0; bg = lat_bg; ba = lat_ba; addr = lat_row;
        end else if (do_rd || do_wr) begin
            cs_n = 1'b0; cas_n = 1'b0; we_n = !do_wr;
            bg = lat_bg; ba = lat_ba; addr = ROW_BITS'(lat_col);
        end else if (do_pre) begin
            cs_n = 1'b0; ras_n = 1'b0; we_n = 1'b0; bg = lat_bg; ba = lat_ba;
        end else if (do_prea) begin
            cs_n = 1'b0; ras_n = 1'b0; we_n = 1'b0; addr[10] = 1'b1;
        end else if (do_ref) begin
            cs_n = 1'b0; ras_n = 1'b0; cas_n = 1'b0;
        end
    end

    // Bank table, timers, request latch, refresh latch and data-strobe pipelines.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            bank_open <= '0;
            ref_pend  <= 1'b0;
            lat_write <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            rd_pipe   <= '0;
            wr_pipe   <= '0;
            for (int i = 0; i < NB; i++) tras_cnt[i] <= '0;
        end else begin
            timer <= (timer != 0) ? timer - 1'b1 : '0;
            if (do_pre || do_prea) timer <= TW'(T_RP - 1);
            if (do_act)            timer <= TW'(T_RCD - 1);
            if (do_ref)            timer <= TW'(T_RFC);
            for (int i = 0; i < NB; i++)
                if (tras_cnt[i] != 0) tras_cnt[i] <= tras_cnt[i] - 1'b1;
            if (do_act) begin
                bank_open[lat_idx] <= 1'b1;
                bank_row[lat_idx]  <= lat_row;
                tras_cnt[lat_idx]  <= RW'(T_RAS - 1);
            end
            if (do_pre)  bank_open[lat_idx] <= 1'b0;
            if (do_prea) bank_open <= '0;
            if (accept) begin
                lat_write <= req_write;
                lat_bg    <= req_bg;
                lat_ba    <= req_ba;
                lat_row   <= req_row;
                lat_col   <= req_col;
            end
            if (do_ref)                     ref_pend <= 1'b0;
            else if (refresh || auto_tick) ref_pend <= 1'b1;
            rd_pipe <= {rd_pipe[CL-2:0], do_rd};
            wr_pipe <= {wr_pipe[CWL-2:0], do_wr};
        end
    end

endmodule
